// File: rtl/img_job_sequencer.sv
// rtl/img_job_sequencer.sv - queued job launcher with ID tagging and watchdog for the image core
//
// Purpose:
//   Buffers up to DEPTH image-job descriptors and launches them one at a time on the
//   core's start/idle/exit handshake. Each job produces exactly one completion record
//   (id, exit code, timeout flag). A watchdog retires jobs whose core never comes back.
//
// Ports:
//   clk_i, rst_i                    clock, asynchronous active-high reset
//   job_valid_i/job_ready_o         descriptor push handshake
//   job_id_i, job_desc_i            job tag and 8 packed descriptor fields (src_width at LSBs)
//   tmo_cycles_i                    watchdog limit, 0 disables
//   src_*_o, dst_*_o                descriptor fields presented to the core
//   start_o, idle_i, exit_i         core launch pulse, core idle, core exit code
//   done_valid_o/done_ready_i       completion record handshake
//   done_id_o, done_exit_o, done_tmo_o  completion record contents
//   pending_o, busy_o               FIFO occupancy, sequencer not idle
module img_job_sequencer #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int ID_W   = 4,
  parameter int TMO_W  = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       job_valid_i,
  output logic                       job_ready_o,
  input  logic [ID_W-1:0]            job_id_i,
  input  logic [8*DATA_W-1:0]        job_desc_i,
  input  logic [TMO_W-1:0]           tmo_cycles_i,
  output logic [DATA_W-1:0]          src_width_o,
  output logic [DATA_W-1:0]          src_height_o,
  output logic [DATA_W-1:0]          src_offset_addr_o,
  output logic [DATA_W-1:0]          src_image_size_o,
  output logic [DATA_W-1:0]          dst_width_o,
  output logic [DATA_W-1:0]          dst_height_o,
  output logic [DATA_W-1:0]          dst_offset_addr_o,
  output logic [DATA_W-1:0]          dst_image_size_o,
  output logic                       start_o,
  input  logic                       idle_i,
  input  logic [DATA_W-1:0]          exit_i,
  output logic                       done_valid_o,
  input  logic                       done_ready_i,
  output logic [ID_W-1:0]            done_id_o,
  output logic [DATA_W-1:0]          done_exit_o,
  output logic                       done_tmo_o,
  output logic [$clog2(DEPTH+1)-1:0] pending_o,
  output logic                       busy_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_LAUNCH   = 3'd1;
  localparam logic [2:0] S_WAIT_ACK = 3'd2;
  localparam logic [2:0] S_RUN      = 3'd3;
  localparam logic [2:0] S_RETIRE   = 3'd4;

  logic [8*DATA_W-1:0] r_desc_mem [DEPTH];
  logic [ID_W-1:0]     r_id_mem   [DEPTH];
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [CNT_W-1:0]    r_count;
  logic [2:0]          r_state;
  logic [TMO_W-1:0]    r_wd;
  logic [8*DATA_W-1:0] r_desc;
  logic [ID_W-1:0]     r_id;
  logic [DATA_W-1:0]   r_exit;
  logic                r_tmo;

  logic w_full;
  logic w_push;
  logic w_pop;
  logic w_wd_expired;

  // Ready comes from registered occupancy only, so a pop in the same cycle never
  // opens a slot early. It is also held low while reset is asserted.
  assign w_full       = (r_count == CNT_W'(DEPTH));
  assign job_ready_o  = !rst_i && !w_full;
  assign w_push       = job_valid_i && job_ready_o;
  // Launch only into an idle core; after a watchdog retire this stalls the queue
  // until the hung core recovers instead of double-starting it.
  assign w_pop        = (r_state == S_IDLE) && (r_count != '0) && idle_i;
  assign w_wd_expired = (tmo_cycles_i != '0) && (r_wd == tmo_cycles_i - TMO_W'(1));

  // Descriptor storage carries no reset: entries are only read after being written.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_desc_mem[r_wr_ptr] <= job_desc_i;
      r_id_mem[r_wr_ptr]   <= job_id_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_state  <= S_IDLE;
      r_wd     <= '0;
      r_desc   <= '0;
      r_id     <= '0;
      r_exit   <= '0;
      r_tmo    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase

      unique case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_desc  <= r_desc_mem[r_rd_ptr];
            r_id    <= r_id_mem[r_rd_ptr];
            r_state <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          r_wd    <= '0;
          r_state <= S_WAIT_ACK;
        end
        S_WAIT_ACK: begin
          r_wd <= r_wd + TMO_W'(1);
          if (w_wd_expired) begin
            r_exit  <= '1;
            r_tmo   <= 1'b1;
            r_state <= S_RETIRE;
          end else if (!idle_i) begin
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_wd <= r_wd + TMO_W'(1);
          // A completion landing in the expiry cycle beats the watchdog.
          if (idle_i) begin
            r_exit  <= exit_i;
            r_tmo   <= 1'b0;
            r_state <= S_RETIRE;
          end else if (w_wd_expired) begin
            r_exit  <= '1;
            r_tmo   <= 1'b1;
            r_state <= S_RETIRE;
          end
        end
        S_RETIRE: begin
          if (done_ready_i) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign src_width_o       = r_desc[0*DATA_W +: DATA_W];
  assign src_height_o      = r_desc[1*DATA_W +: DATA_W];
  assign src_offset_addr_o = r_desc[2*DATA_W +: DATA_W];
  assign src_image_size_o  = r_desc[3*DATA_W +: DATA_W];
  assign dst_width_o       = r_desc[4*DATA_W +: DATA_W];
  assign dst_height_o      = r_desc[5*DATA_W +: DATA_W];
  assign dst_offset_addr_o = r_desc[6*DATA_W +: DATA_W];
  assign dst_image_size_o  = r_desc[7*DATA_W +: DATA_W];

  assign start_o      = (r_state == S_LAUNCH);
  assign done_valid_o = (r_state == S_RETIRE);
  assign busy_o       = (r_state != S_IDLE);
  assign done_id_o    = r_id;
  assign done_exit_o  = r_exit;
  assign done_tmo_o   = r_tmo;
  assign pending_o    = r_count;

endmodule

// File: tb/tb_img_job_sequencer.sv
// tb/tb_img_job_sequencer.sv - randomized self-checking bench for img_job_sequencer
module tb_img_job_sequencer;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
  localparam int ID_W   = 4;
  localparam int TMO_W  = 32;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic                clk_i = 1'b0;
  logic                rst_i;
  logic                job_valid_i;
  logic                job_ready_o;
  logic [ID_W-1:0]     job_id_i;
  logic [8*DATA_W-1:0] job_desc_i;
  logic [TMO_W-1:0]    tmo_cycles_i;
  logic [DATA_W-1:0]   src_width_o, src_height_o, src_offset_addr_o, src_image_size_o;
  logic [DATA_W-1:0]   dst_width_o, dst_height_o, dst_offset_addr_o, dst_image_size_o;
  logic                start_o;
  logic                idle_i;
  logic [DATA_W-1:0]   exit_i;
  logic                done_valid_o;
  logic                done_ready_i;
  logic [ID_W-1:0]     done_id_o;
  logic [DATA_W-1:0]   done_exit_o;
  logic                done_tmo_o;
  logic [CNT_W-1:0]    pending_o;
  logic                busy_o;
  logic [8*DATA_W-1:0] desc_out;

  always #5 clk_i = ~clk_i;

  img_job_sequencer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ID_W(ID_W), .TMO_W(TMO_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .job_valid_i(job_valid_i), .job_ready_o(job_ready_o),
    .job_id_i(job_id_i), .job_desc_i(job_desc_i), .tmo_cycles_i(tmo_cycles_i),
    .src_width_o(src_width_o), .src_height_o(src_height_o),
    .src_offset_addr_o(src_offset_addr_o), .src_image_size_o(src_image_size_o),
    .dst_width_o(dst_width_o), .dst_height_o(dst_height_o),
    .dst_offset_addr_o(dst_offset_addr_o), .dst_image_size_o(dst_image_size_o),
    .start_o(start_o), .idle_i(idle_i), .exit_i(exit_i),
    .done_valid_o(done_valid_o), .done_ready_i(done_ready_i),
    .done_id_o(done_id_o), .done_exit_o(done_exit_o), .done_tmo_o(done_tmo_o),
    .pending_o(pending_o), .busy_o(busy_o)
  );

  assign desc_out = {dst_image_size_o, dst_offset_addr_o, dst_height_o, dst_width_o,
                     src_image_size_o, src_offset_addr_o, src_height_o, src_width_o};

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference model: queued jobs, the one job in flight, and the emulated core.
  logic [ID_W-1:0]     q_id   [$];
  logic [8*DATA_W-1:0] q_desc [$];
  bit                  sb_valid = 0;
  logic [ID_W-1:0]     sb_id;
  logic [DATA_W-1:0]   sb_exit;
  bit                  sb_tmo;
  int                  sb_first;
  bit                  c_active = 0;
  int                  c_lo, c_hi;
  logic [DATA_W-1:0]   c_exit = '0;
  int                  force_a = -1, force_r = -1;
  bit                  use_force_exit = 0;
  logic [DATA_W-1:0]   force_exit = '0;
  int                  p_ready = 100, p_push = 0;
  int                  n_starts = 0, last_start = 0, n_done = 0, last_done_first = 0;
  bit                  seen_first = 0, last_done_tmo = 0;
  logic [DATA_W-1:0]   last_done_exit = '0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [8*DATA_W-1:0] rand_desc();
    logic [8*DATA_W-1:0] d;
    for (int f = 0; f < 8; f++) d[f*DATA_W +: DATA_W] = $urandom;
    return d;
  endfunction

  task automatic observe();
    int a, r, t;
    logic [8*DATA_W-1:0] d;
    if (start_o) begin
      check_eq("start_while_busy", sb_valid, 0);
      check_eq("start_core_idle", idle_i, 1);
      check_eq("start_queue_nonempty", q_id.size() != 0, 1);
      if (q_id.size() != 0) begin
        d     = q_desc.pop_front();
        sb_id = q_id.pop_front();
        for (int f = 0; f < 8; f++)
          check_eq($sformatf("desc_field%0d", f), desc_out[f*DATA_W +: DATA_W], d[f*DATA_W +: DATA_W]);
        a        = (force_a >= 0) ? force_a : int'($urandom_range(0, 2));
        r        = (force_r >= 0) ? force_r : int'($urandom_range(3, 30));
        c_lo     = cyc + a;
        c_hi     = cyc + a + r;
        c_active = 1;
        c_exit   = use_force_exit ? force_exit : DATA_W'($urandom);
        t        = int'(tmo_cycles_i);
        // Watchdog fires t cycles after LAUNCH unless the core finished first or in that cycle.
        if (t != 0 && cyc + t < c_hi) begin
          sb_exit = '1; sb_tmo = 1; sb_first = cyc + t + 1;
        end else begin
          sb_exit = c_exit; sb_tmo = 0; sb_first = c_hi + 1;
        end
        sb_valid   = 1;
        seen_first = 0;
        n_starts++;
        last_start = cyc;
      end
    end
    check_eq("pending", pending_o, q_id.size());
    check_eq("job_ready", job_ready_o, q_id.size() < DEPTH);
    check_eq("busy", busy_o, sb_valid);
    check_eq("done_valid", done_valid_o, sb_valid && cyc >= sb_first);
    if (done_valid_o && sb_valid) begin
      check_eq("done_id", done_id_o, sb_id);
      check_eq("done_exit", done_exit_o, sb_exit);
      check_eq("done_tmo", done_tmo_o, sb_tmo);
      if (!seen_first) begin
        seen_first      = 1;
        last_done_first = cyc;
      end
      last_done_tmo  = done_tmo_o;
      last_done_exit = done_exit_o;
    end
  endtask

  task automatic drive();
    idle_i = !(c_active && cyc >= c_lo && cyc < c_hi);
    if (c_active && cyc >= c_hi) c_active = 0;
    exit_i       = c_exit;
    done_ready_i = ($urandom_range(0, 99) < p_ready);
    if (p_push > 0) begin
      job_valid_i = ($urandom_range(0, 99) < p_push);
      job_id_i    = ID_W'($urandom);
      job_desc_i  = rand_desc();
    end
  endtask

  task automatic tick();
    bit acc, hs;
    acc = job_valid_i && job_ready_o;
    hs  = done_valid_o && done_ready_i;
    if (acc) begin
      q_id.push_back(job_id_i);
      q_desc.push_back(job_desc_i);
    end
    @(posedge clk_i); #1;
    cyc++;
    if (hs) begin
      sb_valid = 0;
      n_done++;
    end
    observe();
    drive();
  endtask

  task automatic push_job(input logic [ID_W-1:0] id, input int max_wait, output int acc_cyc);
    job_valid_i = 1; job_id_i = id; job_desc_i = rand_desc();
    acc_cyc = -1;
    for (int k = 0; k < max_wait && acc_cyc < 0; k++) begin
      if (job_ready_o) acc_cyc = cyc;
      tick();
    end
    job_valid_i = 0;
    if (acc_cyc < 0) check_eq("push_wait_ready", job_ready_o, 1);
  endtask

  task automatic wait_starts(input int n, input int bound);
    for (int k = 0; k < bound && n_starts < n; k++) tick();
    check_eq("wait_start", n_starts >= n, 1);
  endtask

  task automatic wait_done(input int n, input int bound);
    for (int k = 0; k < bound && n_done < n; k++) tick();
    check_eq("wait_done", n_done >= n, 1);
  endtask

  task automatic drain();
    p_push = 0; job_valid_i = 0; p_ready = 100;
    for (int k = 0; k < 3000 && (q_id.size() != 0 || sb_valid || c_active); k++) tick();
    check_eq("drain", q_id.size() != 0 || sb_valid, 0);
  endtask

  task automatic check_reset(input string tag);
    check_eq({tag, "_start"}, start_o, 0);
    check_eq({tag, "_done_valid"}, done_valid_o, 0);
    check_eq({tag, "_ready"}, job_ready_o, 0);
    check_eq({tag, "_pending"}, pending_o, 0);
    check_eq({tag, "_busy"}, busy_o, 0);
    check_eq({tag, "_done_id"}, done_id_o, 0);
    check_eq({tag, "_done_exit"}, done_exit_o, 0);
    check_eq({tag, "_done_tmo"}, done_tmo_o, 0);
    for (int f = 0; f < 8; f++) check_eq({tag, "_desc"}, desc_out[f*DATA_W +: DATA_W], 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int p, base, hung_hi, s0;
    rst_i = 1; job_valid_i = 0; job_id_i = '0; job_desc_i = '0; tmo_cycles_i = '0;
    idle_i = 1; exit_i = '0; done_ready_i = 0;
    repeat (2) @(posedge clk_i);
    #1;
    check_reset("rst0");
    rst_i = 0;
    #1;
    check_eq("ready_after_rst", job_ready_o, 1);

    // Single job, exact launch and completion latency.
    force_a = 1; force_r = 10; use_force_exit = 1; force_exit = 32'h5;
    push_job(4'd3, 10, p);
    wait_starts(1, 10);
    check_eq("t1_start_lat", last_start - p, 2);
    wait_done(1, 40);
    check_eq("t1_done_lat", last_done_first - last_start, 12);
    check_eq("t1_done_tmo", last_done_tmo, 0);
    check_eq("t1_done_exit", last_done_exit, 32'h5);
    repeat (5) tick();
    check_eq("t1_single_start", n_starts, 1);
    use_force_exit = 0;

    // Fill the FIFO behind a long-running job.
    force_a = 0; force_r = 40;
    base = n_done;
    push_job(4'd1, 10, p);
    wait_starts(n_starts + 1, 10);
    for (int i = 0; i < 4; i++) push_job(ID_W'(i + 8), 10, p);
    check_eq("t2_full_ready", job_ready_o, 0);
    check_eq("t2_full_pending", pending_o, 4);
    force_a = -1; force_r = -1;
    push_job(4'd12, 100, p);
    wait_done(base + 6, 800);
    drain();

    // Hung core: watchdog retire, then the next launch waits for idle.
    tmo_cycles_i = 20; force_a = 0; force_r = 60;
    base = n_done;
    push_job(4'd5, 10, p);
    wait_starts(n_starts + 1, 10);
    hung_hi = c_hi;
    s0 = last_start;
    push_job(4'd6, 10, p);
    wait_done(base + 1, 60);
    check_eq("t3_tmo_lat", last_done_first - s0, 21);
    check_eq("t3_tmo_flag", last_done_tmo, 1);
    check_eq("t3_tmo_exit", last_done_exit, 32'hFFFF_FFFF);
    force_a = -1; force_r = 5;
    wait_starts(n_starts + 1, 100);
    check_eq("t3_no_early_launch", last_start > hung_hi, 1);
    drain();

    // Completion exactly in the expiry cycle wins; one cycle later it does not.
    force_a = 1; force_r = 19;
    base = n_done;
    push_job(4'd7, 10, p);
    wait_done(base + 1, 60);
    check_eq("t4_tie_tmo", last_done_tmo, 0);
    force_r = 20;
    push_job(4'd8, 10, p);
    wait_done(base + 2, 60);
    check_eq("t4_late_tmo", last_done_tmo, 1);
    drain();

    // Completion back-pressure.
    tmo_cycles_i = 0; p_ready = 0; force_a = 0; force_r = 5;
    push_job(4'd9, 10, p);
    wait_starts(n_starts + 1, 10);
    push_job(4'd10, 10, p);
    for (int k = 0; k < 50 && !done_valid_o; k++) tick();
    check_eq("t5_reach_done", done_valid_o, 1);
    s0 = n_starts;
    push_job(4'd11, 10, p);
    repeat (14) tick();
    check_eq("t5_no_start", n_starts, s0);
    check_eq("t5_done_held", done_valid_o, 1);
    check_eq("t5_pending", pending_o, 2);
    p_ready = 100; force_r = -1; force_a = -1;
    wait_starts(s0 + 1, 20);
    drain();

    // Randomized traffic in several watchdog settings.
    for (int ph = 0; ph < 4; ph++) begin
      tmo_cycles_i = (ph % 2 == 0) ? '0 : TMO_W'($urandom_range(3, 25));
      p_push = 30; p_ready = 60;
      repeat (400) tick();
      drain();
    end

    // Reset in the middle of a job with two queued behind it.
    force_a = 0; force_r = 50;
    push_job(4'd2, 10, p);
    wait_starts(n_starts + 1, 10);
    push_job(4'd4, 10, p);
    push_job(4'd6, 10, p);
    repeat (3) tick();
    rst_i = 1;
    #1;
    check_reset("rst_mid");
    q_id.delete(); q_desc.delete();
    sb_valid = 0; c_active = 0; idle_i = 1; exit_i = '0; c_exit = '0;
    @(posedge clk_i); #1;
    cyc++;
    rst_i = 0;
    #1;
    s0 = n_starts;
    repeat (10) tick();
    check_eq("t6_no_start", n_starts, s0);
    force_a = -1; force_r = -1;
    base = n_done;
    push_job(4'd13, 10, p);
    wait_done(base + 1, 60);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/img_job_sequencer.md
Name: img_job_sequencer

Overview:
- Parametrised job front-end for the custom-instruction CVA6 image-processing core.
- Buffers up to DEPTH image-job descriptors (src/dst geometry, offsets, sizes) and launches them back-to-back on the core's start/idle/exit interface.
- Returns one completion record per job (id, exit code, timeout flag).
- Adds queuing, ID tagging and watchdog timeout, none of which the single-shot register interface has.

Parameters:
- DATA_W, 32, width of every descriptor field and of the exit code
- DEPTH, 4, descriptor FIFO entries (power of 2, >=2)
- ID_W, 4, job tag width
- TMO_W, 32, watchdog counter width

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous reset, active-high
- job_valid_i  in  1  descriptor push valid
- job_ready_o  out  1  FIFO not full
- job_id_i  in  ID_W  tag returned on completion
- job_desc_i  in  8*DATA_W  {dst_image_size, dst_offset_addr, dst_height, dst_width, src_image_size, src_offset_addr, src_height, src_width}, src_width at LSBs
- tmo_cycles_i  in  TMO_W  watchdog limit; 0 disables
- src_width_o, src_height_o, src_offset_addr_o, src_image_size_o  out  DATA_W each  to core
- dst_width_o, dst_height_o, dst_offset_addr_o, dst_image_size_o  out  DATA_W each  to core
- start_o  out  1  one-cycle launch pulse to core
- idle_i  in  1  core idle
- exit_i  in  DATA_W  core exit code
- done_valid_o  out  1  completion record valid
- done_ready_i  in  1  completion accepted
- done_id_o  out  ID_W  tag of completed job
- done_exit_o  out  DATA_W  exit code, or all-ones on timeout
- done_tmo_o  out  1  job ended by watchdog
- pending_o  out  clog2(DEPTH+1)  FIFO occupancy
- busy_o  out  1  FSM not in IDLE

Behaviour:
Reset:
- All outputs and registers are 0; FIFO is empty; FSM is in IDLE.
- job_ready_o is 1 from the first cycle after reset deasserts.
- Reset asserted mid-job: everything clears immediately, including the queued jobs and any pending completion. No completion is emitted for the aborted job.

FIFO:
- A push occurs on a clock edge where job_valid_i && job_ready_o.
- job_ready_o = !full, computed from registered occupancy. When full it stays 0 even if a pop happens in the same cycle.
- Pointers wrap modulo DEPTH.
- pending_o increments on push, decrements on pop, and is unchanged when both happen in the same cycle.

FSM states: IDLE, LAUNCH, WAIT_ACK, RUN, RETIRE.
- IDLE:
  - If occupancy != 0 and idle_i == 1: pop the head, register all 8 fields and the id into the output registers, go to LAUNCH.
  - A job pushed into an empty FIFO therefore pops on the next edge: start_o is 1 in the second cycle after the accepting edge.
- LAUNCH: start_o = 1 for exactly this one cycle; watchdog counter cleared; go to WAIT_ACK.
- WAIT_ACK: wait for idle_i == 0, then go to RUN. The core is permitted to drop idle_i in the same cycle as start_o or later.
- RUN: when idle_i == 1, capture exit_i into done_exit_o, set done_tmo_o = 0, go to RETIRE.
- Watchdog (WAIT_ACK and RUN):
  - The counter increments every cycle in these two states.
  - If tmo_cycles_i != 0 and counter == tmo_cycles_i - 1: done_exit_o = all ones, done_tmo_o = 1, go to RETIRE.
  - If idle_i rises in the timeout cycle, the normal completion wins.
- RETIRE:
  - done_valid_o = 1; done_id/exit/tmo are held stable until done_valid_o && done_ready_i.
  - On that handshake: done_valid_o = 0, go to IDLE.
- Stability: the descriptor outputs hold their value from LAUNCH until the next pop; they do not change while a job is running.
- After a timeout, the next launch waits in IDLE until idle_i == 1. A hung core therefore stalls the queue but never double-starts.
- busy_o = (state != IDLE).
- Pushes are accepted in every state.

Test Plan:
- Single job, exit_i=0x5, core drops idle 1 cycle after start and raises it 10 cycles later, done_ready_i=1 -> one start pulse 2 cycles after push; done_valid_o for 1 cycle with id=3, exit=0x5, tmo=0.
- Push 5 jobs back-to-back with DEPTH=4 while core busy -> job_ready_o=0 after the 4th push; pending_o reaches 4; all 5 complete in push order with correct ids and descriptor fields matching job_desc_i slices.
- tmo_cycles_i=20, core never returns idle -> done_tmo_o=1, done_exit_o=0xFFFFFFFF exactly 20 cycles after leaving LAUNCH; next job not launched until idle_i=1.
- idle_i rises exactly in the timeout cycle -> done_tmo_o=0 and exit_i captured.
- done_ready_i held 0 for 15 cycles -> done fields stable, no new start_o, pushes still accepted; release -> next job launches.
- rst_i asserted during RUN with 2 queued jobs -> all outputs 0 the same cycle; pending_o=0; no start_o or done_valid_o after release until a new push.
